// File: rtl/param_data_memory.sv
// -----------------------------------------------------------------------------
// param_data_memory
//   Parametrised single-port data memory for the CPU datapath. It sits between
//   the load/store stage and the register-file write-back.
//
//   After reset an init sweep writes INIT_VAL to every word, one word per
//   cycle. The sweep takes exactly DEPTH cycles. While the sweep runs,
//   req_ready stays low and requests are ignored. When the sweep ends,
//   req_ready and init_done rise together and stay high until the next reset.
//
//   Each accepted request (req_valid & req_ready) gets a one-cycle rsp_valid
//   pulse on the next cycle. Writes return the old word (read-before-write).
//   An address >= DEPTH leaves memory unchanged and returns rdata=0, err=1.
//
// Parameters
//   DATA_W    data word width
//   ADDR_W    address width
//   DEPTH     number of words, 1 <= DEPTH <= 2**ADDR_W
//   INIT_VAL  value written to every word by the init sweep
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   req_valid  in   request present
//   req_ready  out  request accepted this cycle when req_valid is high
//   req_write  in   1 = write, 0 = read
//   req_addr   in   word address
//   req_wdata  in   write data
//   rsp_valid  out  one-cycle response pulse
//   rsp_rdata  out  read data (old contents for writes)
//   rsp_err    out  address was out of range
//   init_done  out  init sweep has completed
// -----------------------------------------------------------------------------
module param_data_memory #(
  parameter int                 DATA_W   = 8,
  parameter int                 ADDR_W   = 4,
  parameter int                 DEPTH    = 16,
  parameter logic [DATA_W-1:0]  INIT_VAL = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              init_done
);

  // The storage index only needs enough bits to cover DEPTH words. In-range
  // addresses and sweep pointers never set the bits above that.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // The pointer and the comparison constants are ADDR_W+1 bits wide, so
  // DEPTH == 2**ADDR_W can be represented and the sweep ends correctly.
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_C  = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W + 1)'(1);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              state_r;
  state_t              state_n_s;
  logic [ADDR_W:0]     ptr_r;
  logic [ADDR_W:0]     ptr_n_s;

  logic                req_ready_r;
  logic                init_done_r;
  logic                rsp_valid_r;
  logic [DATA_W-1:0]   rsp_rdata_r;
  logic                rsp_err_r;

  logic                accept_s;
  logic                in_range_s;
  logic [IDX_W-1:0]    req_idx_s;
  logic [DATA_W-1:0]   rd_data_s;

  logic                mem_we_s;
  logic [IDX_W-1:0]    mem_widx_s;
  logic [DATA_W-1:0]   mem_wdata_s;

  logic [DATA_W-1:0]   mem_r [0:DEPTH-1];

  // Decode the address and read the array combinationally. The array read
  // returns the old word even when the same cycle writes that address.
  always_comb begin
    accept_s   = 1'b0;
    in_range_s = 1'b0;
    req_idx_s  = req_addr[IDX_W-1:0];
    rd_data_s  = {DATA_W{1'b0}};
    accept_s   = req_valid & req_ready_r;
    in_range_s = ({1'b0, req_addr} < DEPTH_C);
    if (in_range_s) begin
      rd_data_s = mem_r[req_idx_s];
    end else begin
      rd_data_s = {DATA_W{1'b0}};
    end
  end

  // Next-state logic and write-port steering: the sweep owns the write port
  // in INIT, and accepted in-range writes own it in RUN.
  always_comb begin
    state_n_s   = state_r;
    ptr_n_s     = ptr_r;
    mem_we_s    = 1'b0;
    mem_widx_s  = ptr_r[IDX_W-1:0];
    mem_wdata_s = INIT_VAL;
    case (state_r)
      ST_INIT: begin
        mem_we_s    = 1'b1;
        mem_widx_s  = ptr_r[IDX_W-1:0];
        mem_wdata_s = INIT_VAL;
        ptr_n_s     = ptr_r + ONE_C;
        if (ptr_r == LAST_C) begin
          state_n_s = ST_RUN;
        end else begin
          state_n_s = ST_INIT;
        end
      end
      ST_RUN: begin
        state_n_s = ST_RUN;
        if (accept_s && req_write && in_range_s) begin
          mem_we_s    = 1'b1;
          mem_widx_s  = req_idx_s;
          mem_wdata_s = req_wdata;
        end else begin
          mem_we_s    = 1'b0;
        end
      end
      default: begin
        state_n_s = ST_INIT;
        ptr_n_s   = {(ADDR_W + 1){1'b0}};
      end
    endcase
  end

  // State and pointer register. req_ready and init_done are registered from
  // the next state, so both rise on the same edge that enters RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_INIT;
      ptr_r       <= {(ADDR_W + 1){1'b0}};
      req_ready_r <= 1'b0;
      init_done_r <= 1'b0;
    end else begin
      state_r     <= state_n_s;
      ptr_r       <= ptr_n_s;
      req_ready_r <= (state_n_s == ST_RUN);
      init_done_r <= (state_n_s == ST_RUN);
    end
  end

  // Response register. rdata and err only update on accept and otherwise
  // hold. A reset drops any pending pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= {DATA_W{1'b0}};
      rsp_err_r   <= 1'b0;
    end else begin
      rsp_valid_r <= accept_s;
      if (accept_s) begin
        rsp_rdata_r <= rd_data_s;
        rsp_err_r   <= ~in_range_s;
      end
    end
  end

  // Storage array. It has no reset: after reset the init sweep defines its
  // contents.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_widx_s] <= mem_wdata_s;
    end
  end

  assign req_ready = req_ready_r;
  assign init_done = init_done_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_param_data_memory.sv
// -----------------------------------------------------------------------------
// tb_param_data_memory
//   Two instances share one stimulus: DEPTH=16 (index 0) and DEPTH=12
//   (index 1). Each instance has its own reference model. The model counts
//   cycles since reset, treats the instance as ready once that count reaches
//   DEPTH, and keeps the memory as a plain array.
// -----------------------------------------------------------------------------
module tb_param_data_memory;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_write;
  logic [3:0] req_addr;
  logic [7:0] req_wdata;

  logic       rdy  [2];
  logic       vld  [2];
  logic [7:0] rdat [2];
  logic       err  [2];
  logic       done [2];

  int checks = 0;
  int errors = 0;

  // Reference model state, per instance.
  int         depth  [2] = '{16, 12};
  int         since  [2];
  logic [7:0] mmem   [2][16];
  logic       exp_v  [2];
  logic [7:0] exp_d  [2];
  logic       exp_e  [2];

  always #5 clk = ~clk;

  param_data_memory #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .INIT_VAL(8'h00)) u_dut16 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy[0]),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(vld[0]), .rsp_rdata(rdat[0]), .rsp_err(err[0]), .init_done(done[0])
  );

  param_data_memory #(.DATA_W(8), .ADDR_W(4), .DEPTH(12), .INIT_VAL(8'h00)) u_dut12 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy[1]),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(vld[1]), .rsp_rdata(rdat[1]), .rsp_err(err[1]), .init_done(done[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, advance the models on the edge, then compare just after the edge.
  task automatic step(input logic rst, input logic v, input logic w,
                      input logic [3:0] a, input logic [7:0] d);
    logic rdy_m;
    @(negedge clk);
    reset = rst; req_valid = v; req_write = w; req_addr = a; req_wdata = d;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        since[k] = 0;
        exp_v[k] = 1'b0;
        exp_d[k] = 8'h00;
        exp_e[k] = 1'b0;
        for (int j = 0; j < 16; j++) mmem[k][j] = 8'h00;
      end else begin
        rdy_m = (since[k] >= depth[k]);
        if (rdy_m && v) begin
          exp_v[k] = 1'b1;
          if (int'(a) < depth[k]) begin
            exp_d[k] = mmem[k][a];
            exp_e[k] = 1'b0;
            if (w) mmem[k][a] = d;
          end else begin
            exp_d[k] = 8'h00;
            exp_e[k] = 1'b1;
          end
        end else begin
          exp_v[k] = 1'b0;
        end
        if (since[k] < depth[k]) since[k]++;
      end
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("ready[%0d]", k), 32'(rdy[k]), 32'(since[k] >= depth[k]));
      chk($sformatf("init_done[%0d]", k), 32'(done[k]), 32'(since[k] >= depth[k]));
      chk($sformatf("rsp_valid[%0d]", k), 32'(vld[k]), 32'(exp_v[k]));
      if (exp_v[k]) begin
        chk($sformatf("rsp_rdata[%0d]", k), 32'(rdat[k]), 32'(exp_d[k]));
        chk($sformatf("rsp_err[%0d]", k), 32'(err[k]), 32'(exp_e[k]));
      end
    end
  endtask

  initial begin
    logic       r_v;
    logic       r_w;
    logic       r_rst;
    logic [3:0] r_a;
    logic [7:0] r_d;

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 4'd0; req_wdata = 8'h00;

    // Check the reset state, then check that DEPTH=16 stays not-ready for 16 cycles.
    step(1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
    chk("reset_rdata", 32'(rdat[0]), 32'h0);
    chk("reset_err", 32'(err[0]), 32'h0);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
      chk($sformatf("init_ready16_cyc%0d", i), 32'(rdy[0]), 32'(i == 15));
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 1'b0, 4'(i), 8'h00);
      chk($sformatf("init_val_addr%0d", i), 32'(rdat[0]), 32'h0);
    end

    // Write then read the same address on the next cycle.
    step(1'b0, 1'b1, 1'b1, 4'd3, 8'hA5);
    chk("wr3_old", 32'(rdat[0]), 32'h00);
    chk("wr3_err", 32'(err[0]), 32'h0);
    step(1'b0, 1'b1, 1'b0, 4'd3, 8'h00);
    chk("rd3_new", 32'(rdat[0]), 32'hA5);

    // Back-to-back writes and reads; rsp_valid stays high for all four.
    step(1'b0, 1'b1, 1'b1, 4'd1, 8'h11);
    chk("b2b_v0", 32'(vld[0]), 32'h1);
    step(1'b0, 1'b1, 1'b1, 4'd2, 8'h22);
    chk("b2b_v1", 32'(vld[0]), 32'h1);
    step(1'b0, 1'b1, 1'b0, 4'd1, 8'h00);
    chk("b2b_rd1", 32'(rdat[0]), 32'h11);
    step(1'b0, 1'b1, 1'b0, 4'd2, 8'h00);
    chk("b2b_rd2", 32'(rdat[0]), 32'h22);
    step(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    chk("b2b_idle", 32'(vld[0]), 32'h0);

    // Out-of-range access on DEPTH=12; the aliased word must be untouched.
    step(1'b0, 1'b1, 1'b1, 4'd13, 8'hFF);
    chk("oor_wr_err", 32'(err[1]), 32'h1);
    chk("oor_wr_rdata", 32'(rdat[1]), 32'h0);
    step(1'b0, 1'b1, 1'b0, 4'd13, 8'h00);
    chk("oor_rd_err", 32'(err[1]), 32'h1);
    chk("oor_rd_rdata", 32'(rdat[1]), 32'h0);
    step(1'b0, 1'b1, 1'b0, 4'd1, 8'h00);
    chk("alias_mem1", 32'(rdat[1]), 32'h11);

    // Reset while a response is pending, with requests held valid during the sweep.
    step(1'b0, 1'b1, 1'b0, 4'd3, 8'h00);
    chk("pre_rst_rd3", 32'(rdat[0]), 32'hA5);
    step(1'b1, 1'b1, 1'b0, 4'd3, 8'h00);
    chk("rst_drop_valid", 32'(vld[0]), 32'h0);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 1'b0, 4'd3, 8'h00);
      chk($sformatf("init_no_rsp%0d", i), 32'(vld[0]), 32'h0);
    end
    step(1'b0, 1'b1, 1'b0, 4'd3, 8'h00);
    chk("post_init_v", 32'(vld[0]), 32'h1);
    chk("post_init_rd3", 32'(rdat[0]), 32'h00);

    // Random traffic, with occasional resets, checked against the models.
    for (int i = 0; i < 2000; i++) begin
      r_rst = ($urandom_range(0, 299) == 0);
      r_v   = ($urandom_range(0, 3) != 0);
      r_w   = 1'($urandom_range(0, 1));
      r_a   = 4'($urandom_range(0, 15));
      r_d   = 8'($urandom);
      step(r_rst, r_v, r_w, r_a, r_d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
